anton_neopixel_bus_arbiter: RTL and testbench

ANTON_NEOPIXEL_BUS_ARBITER -- requirements
Module: anton_neopixel_bus_arbiter

---
 rtl/anton_neopixel_bus_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_anton_neopixel_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/anton_neopixel_bus_arbiter.sv
// -----------------------------------------------------------------------------
// anton_neopixel_bus_arbiter
//
// Purpose:
//   Shares one neopixel register bus between two requesters (A and B).
//   Round-robin arbitration with optional locked bursts, single-cycle bus
//   strobes and a programmable read latency.
//
// Ports:
//   busClk, busResetN               clock, asynchronous active-low reset
//   reqX, lockX, addrX, dataInX,    requester X (X = A/B) request, burst lock,
//   writeX, readX                   address, write data and operation
//   grantX, ackX, dataOutX          X owns the bus, 1-cycle completion pulse,
//                                   last read data for X
//   busAddr, busDataIn,             shared bus address / write data / strobes
//   busWrite, busRead, busDataOut   and read data returned by the bus
//   busy                            high whenever the FSM is not IDLE
//   dbg_state                       current FSM state (IDLE/ACCESS/WAIT/DONE)
//
// Handshake:
//   A requester raises reqX with its fields and holds them until ackX.
//   The fields are latched once (in IDLE, or in DONE for a burst follow-on),
//   so later changes are ignored. ackX is a one-cycle pulse that is only
//   ever high while grantX is high; dropping reqX early never aborts the
//   transaction in flight. When both writeX and readX are set the access is
//   a write; with neither set the transaction acks without a bus strobe.
// -----------------------------------------------------------------------------
module anton_neopixel_bus_arbiter #(
  parameter int ADDR_BITS    = 18,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 16
) (
  input  logic                 busClk,
  input  logic                 busResetN,
  input  logic                 reqA,
  input  logic                 lockA,
  input  logic [ADDR_BITS-1:0] addrA,
  input  logic [7:0]           dataInA,
  input  logic                 writeA,
  input  logic                 readA,
  input  logic                 reqB,
  input  logic                 lockB,
  input  logic [ADDR_BITS-1:0] addrB,
  input  logic [7:0]           dataInB,
  input  logic                 writeB,
  input  logic                 readB,
  output logic                 grantA,
  output logic                 ackA,
  output logic [7:0]           dataOutA,
  output logic                 grantB,
  output logic                 ackB,
  output logic [7:0]           dataOutB,
  output logic [ADDR_BITS-1:0] busAddr,
  output logic [7:0]           busDataIn,
  output logic                 busWrite,
  output logic                 busRead,
  input  logic [7:0]           busDataOut,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Index of the last WAIT cycle; WAIT is never entered when READ_LATENCY=0.
  localparam int            LW        = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
  localparam logic [2:0]    LAST_WAIT = 3'(LW);
  localparam logic [7:0]    MAX_B     = 8'(MAX_BURST);

  state_t                 state_q, state_d;
  logic                   grant_a_q, grant_a_d;
  logic                   grant_b_q, grant_b_d;
  logic                   last_b_q, last_b_d;     // 1: B was granted last
  logic [7:0]             burst_cnt_q, burst_cnt_d;
  logic [2:0]             wait_cnt_q, wait_cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   wr_q, wr_d;
  logic                   rd_q, rd_d;
  logic [7:0]             dout_a_q, dout_a_d;
  logic [7:0]             dout_b_q, dout_b_d;

  // Arbitration and field-latch selection.
  logic                   pick_b;
  logic                   lat_b;
  logic [ADDR_BITS-1:0]   lat_addr;
  logic [7:0]             lat_data;
  logic                   lat_wr;
  logic                   lat_rd;
  logic                   own_req;
  logic                   own_lock;

  // On a tie the requester not granted last wins.
  assign pick_b   = reqB & (~reqA | ~last_b_q);
  // New fields come from the fresh winner in IDLE, else from the burst owner.
  assign lat_b    = (state_q == IDLE) ? pick_b : grant_b_q;
  assign lat_addr = lat_b ? addrB   : addrA;
  assign lat_data = lat_b ? dataInB : dataInA;
  assign lat_wr   = lat_b ? writeB  : writeA;
  // Write takes precedence when both operations are requested.
  assign lat_rd   = lat_b ? (readB & ~writeB) : (readA & ~writeA);
  assign own_req  = grant_b_q ? reqB  : reqA;
  assign own_lock = grant_b_q ? lockB : lockA;

  always_comb begin
    state_d     = state_q;
    grant_a_d   = grant_a_q;
    grant_b_d   = grant_b_q;
    last_b_d    = last_b_q;
    burst_cnt_d = burst_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    dout_a_d    = dout_a_q;
    dout_b_d    = dout_b_q;

    case (state_q)
      IDLE: begin
        if (reqA || reqB) begin
          grant_a_d   = ~pick_b;
          grant_b_d   = pick_b;
          addr_d      = lat_addr;
          wdata_d     = lat_data;
          wr_d        = lat_wr;
          rd_d        = lat_rd;
          burst_cnt_d = 8'd1;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        wait_cnt_d = 3'd0;
        if (rd_q) begin
          if (READ_LATENCY == 0) begin
            if (grant_b_q) dout_b_d = busDataOut;
            else           dout_a_d = busDataOut;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end else begin
          // Write, or no operation at all: complete straight away.
          state_d = DONE;
        end
      end

      WAIT: begin
        if (wait_cnt_q == LAST_WAIT) begin
          if (grant_b_q) dout_b_d = busDataOut;
          else           dout_a_d = busDataOut;
          state_d = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end

      DONE: begin
        if (own_lock && own_req && (burst_cnt_q < MAX_B)) begin
          addr_d      = lat_addr;
          wdata_d     = lat_data;
          wr_d        = lat_wr;
          rd_d        = lat_rd;
          burst_cnt_d = burst_cnt_q + 8'd1;
          state_d     = ACCESS;
        end else begin
          last_b_d    = grant_b_q;
          grant_a_d   = 1'b0;
          grant_b_d   = 1'b0;
          burst_cnt_d = 8'd0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge busClk or negedge busResetN) begin
    if (!busResetN) begin
      state_q     <= IDLE;
      grant_a_q   <= 1'b0;
      grant_b_q   <= 1'b0;
      last_b_q    <= 1'b1;
      burst_cnt_q <= 8'd0;
      wait_cnt_q  <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 8'd0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      dout_a_q    <= 8'd0;
      dout_b_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      grant_a_q   <= grant_a_d;
      grant_b_q   <= grant_b_d;
      last_b_q    <= last_b_d;
      burst_cnt_q <= burst_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      dout_a_q    <= dout_a_d;
      dout_b_q    <= dout_b_d;
    end
  end

  // Strobes are decoded from registered state, so they are only high in
  // ACCESS and drop immediately with an asynchronous reset.
  assign busWrite  = (state_q == ACCESS) & wr_q;
  assign busRead   = (state_q == ACCESS) & rd_q;
  assign busAddr   = addr_q;
  assign busDataIn = wdata_q;
  assign grantA    = grant_a_q;
  assign grantB    = grant_b_q;
  assign ackA      = (state_q == DONE) & grant_a_q;
  assign ackB      = (state_q == DONE) & grant_b_q;
  assign dataOutA  = dout_a_q;
  assign dataOutB  = dout_b_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_anton_neopixel_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_anton_neopixel_bus_arbiter
//
// Directed bench for anton_neopixel_bus_arbiter with default parameters
// (ADDR_BITS=18, READ_LATENCY=1, MAX_BURST=16). Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_anton_neopixel_bus_arbiter;

  localparam int AW = 18;

  // Clock / reset
  logic busClk = 1'b0;
  logic busResetN = 1'b0;
  always #5 busClk = ~busClk;

  // Requester A
  logic          reqA, lockA, writeA, readA;
  logic [AW-1:0] addrA;
  logic [7:0]    dataInA;
  logic          grantA, ackA;
  logic [7:0]    dataOutA;
  // Requester B
  logic          reqB, lockB, writeB, readB;
  logic [AW-1:0] addrB;
  logic [7:0]    dataInB;
  logic          grantB, ackB;
  logic [7:0]    dataOutB;
  // Shared bus
  logic [AW-1:0] busAddr;
  logic [7:0]    busDataIn;
  logic          busWrite, busRead;
  logic [7:0]    busDataOut;
  logic          busy;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  anton_neopixel_bus_arbiter dut (
    .busClk     (busClk),
    .busResetN  (busResetN),
    .reqA       (reqA),
    .lockA      (lockA),
    .addrA      (addrA),
    .dataInA    (dataInA),
    .writeA     (writeA),
    .readA      (readA),
    .reqB       (reqB),
    .lockB      (lockB),
    .addrB      (addrB),
    .dataInB    (dataInB),
    .writeB     (writeB),
    .readB      (readB),
    .grantA     (grantA),
    .ackA       (ackA),
    .dataOutA   (dataOutA),
    .grantB     (grantB),
    .ackB       (ackB),
    .dataOutB   (dataOutB),
    .busAddr    (busAddr),
    .busDataIn  (busDataIn),
    .busWrite   (busWrite),
    .busRead    (busRead),
    .busDataOut (busDataOut),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check the always-true invariants.
  task automatic step();
    @(negedge busClk);
    chk("grant_overlap", {31'd0, grantA & grantB}, 32'd0);
    chk("ack_without_grant", {31'd0, (ackA & ~grantA) | (ackB & ~grantB)}, 32'd0);
  endtask

  task automatic idle_inputs();
    reqA = 0; lockA = 0; writeA = 0; readA = 0; addrA = '0; dataInA = 8'h00;
    reqB = 0; lockB = 0; writeB = 0; readB = 0; addrB = '0; dataInB = 8'h00;
  endtask

  task automatic do_reset();
    busResetN = 1'b0;
    idle_inputs();
    step();
    step();
    chk("rst_grantA", {31'd0, grantA}, 32'd0);
    chk("rst_grantB", {31'd0, grantB}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_strobes", {30'd0, busWrite, busRead}, 32'd0);
    chk("rst_busAddr", {14'd0, busAddr}, 32'd0);
    chk("rst_dataOut", {16'd0, dataOutA, dataOutB}, 32'd0);
    busResetN = 1'b1;
    step();
  endtask

  int b_cnt;
  int a_cnt;
  int b_before_a;

  initial begin
    busDataOut = 8'h00;
    idle_inputs();

    // ---------------- single write from A ----------------
    do_reset();
    reqA = 1; writeA = 1; addrA = 18'h00010; dataInA = 8'h5A;
    step();                                   // cycle n+1
    chk("w_grantA", {31'd0, grantA}, 32'd1);
    chk("w_busWrite", {31'd0, busWrite}, 32'd1);
    chk("w_busRead", {31'd0, busRead}, 32'd0);
    chk("w_busAddr", {14'd0, busAddr}, 32'h10);
    chk("w_busDataIn", {24'd0, busDataIn}, 32'h5A);
    chk("w_no_early_ack", {31'd0, ackA}, 32'd0);
    step();                                   // cycle n+2
    chk("w_ackA", {31'd0, ackA}, 32'd1);
    chk("w_strobe_gone", {31'd0, busWrite}, 32'd0);
    reqA = 0; writeA = 0;
    step();
    chk("w_idle_grant", {31'd0, grantA}, 32'd0);
    chk("w_idle_ack", {31'd0, ackA}, 32'd0);
    chk("w_idle_busy", {31'd0, busy}, 32'd0);
    chk("w_addr_held", {14'd0, busAddr}, 32'h10);

    // ---------------- simultaneous reads after reset ----------------
    do_reset();
    busDataOut = 8'h3C;
    reqA = 1; readA = 1; addrA = 18'h00100;
    reqB = 1; readB = 1; addrB = 18'h00200;
    step();                                   // n+1: ACCESS for A
    chk("r_grantA", {31'd0, grantA}, 32'd1);
    chk("r_grantB_low", {31'd0, grantB}, 32'd0);
    chk("r_busRead", {31'd0, busRead}, 32'd1);
    chk("r_busAddrA", {14'd0, busAddr}, 32'h100);
    step();                                   // n+2: WAIT
    chk("r_wait_state", {30'd0, dbg_state}, 32'd2);
    chk("r_read_one_cycle", {31'd0, busRead}, 32'd0);
    chk("r_no_early_ackA", {31'd0, ackA}, 32'd0);
    step();                                   // n+3: DONE
    chk("r_ackA", {31'd0, ackA}, 32'd1);
    chk("r_dataOutA", {24'd0, dataOutA}, 32'h3C);
    reqA = 0; readA = 0;
    step();                                   // n+4: IDLE
    chk("r_gap_grants", {30'd0, grantA, grantB}, 32'd0);
    step();                                   // n+5: ACCESS for B
    chk("r_grantB", {31'd0, grantB}, 32'd1);
    chk("r_busAddrB", {14'd0, busAddr}, 32'h200);
    chk("r_busReadB", {31'd0, busRead}, 32'd1);
    busDataOut = 8'hC3;
    step();                                   // n+6: WAIT
    step();                                   // n+7: DONE
    chk("r_ackB", {31'd0, ackB}, 32'd1);
    chk("r_dataOutB", {24'd0, dataOutB}, 32'hC3);
    chk("r_dataOutA_held", {24'd0, dataOutA}, 32'h3C);
    reqB = 0; readB = 0;
    step();

    // ---------------- write and read both set ----------------
    reqA = 1; writeA = 1; readA = 1; addrA = 18'h00033; dataInA = 8'h77;
    step();
    chk("wr_busWrite", {31'd0, busWrite}, 32'd1);
    chk("wr_busRead", {31'd0, busRead}, 32'd0);
    chk("wr_busAddr", {14'd0, busAddr}, 32'h33);
    step();
    chk("wr_ackA", {31'd0, ackA}, 32'd1);
    chk("wr_busRead_done", {31'd0, busRead}, 32'd0);
    chk("wr_dataOutA_kept", {24'd0, dataOutA}, 32'h3C);
    reqA = 0; writeA = 0; readA = 0;
    step();

    // ---------------- locked burst from B, A waiting ----------------
    // A was granted last, so B wins the opening tie.
    b_cnt = 0; a_cnt = 0; b_before_a = -1;
    reqA = 1; writeA = 1; addrA = 18'h001AA; dataInA = 8'h11;
    reqB = 1; lockB = 1; writeB = 1; addrB = '0; dataInB = 8'h22;
    for (int cyc = 0; cyc < 400 && (b_cnt < 20 || a_cnt < 1); cyc++) begin
      step();
      if (busWrite && grantB) chk("burst_addr", {14'd0, busAddr}, 32'(b_cnt));
      if (ackA) begin
        a_cnt++;
        b_before_a = b_cnt;
        reqA = 0; writeA = 0;
      end
      if (ackB) begin
        b_cnt++;
        addrB = 18'(b_cnt);
        if (b_cnt == 20) begin
          reqB = 0; lockB = 0; writeB = 0;
        end
      end
    end
    chk("burst_b_before_a", 32'(b_before_a), 32'd16);
    chk("burst_a_count", 32'(a_cnt), 32'd1);
    chk("burst_b_total", 32'(b_cnt), 32'd20);
    step();
    step();
    chk("burst_end_idle", {31'd0, busy}, 32'd0);

    // ---------------- reset during WAIT ----------------
    reqA = 1; readA = 1; addrA = 18'h00055;
    step();                                   // ACCESS
    step();                                   // WAIT
    chk("rw_in_wait", {30'd0, dbg_state}, 32'd2);
    busResetN = 1'b0;
    #1;
    chk("rw_grantA", {31'd0, grantA}, 32'd0);
    chk("rw_busy", {31'd0, busy}, 32'd0);
    chk("rw_busRead", {31'd0, busRead}, 32'd0);
    chk("rw_busAddr", {14'd0, busAddr}, 32'd0);
    chk("rw_dataOutA", {24'd0, dataOutA}, 32'd0);
    chk("rw_state", {30'd0, dbg_state}, 32'd0);
    step();
    chk("rw_no_ack", {30'd0, ackA, ackB}, 32'd0);
    idle_inputs();
    step();
    busResetN = 1'b1;
    reqA = 1; writeA = 1; addrA = 18'h00001;
    reqB = 1; writeB = 1; addrB = 18'h00002;
    step();
    chk("rw_tie_grantA", {31'd0, grantA}, 32'd1);
    chk("rw_tie_grantB", {31'd0, grantB}, 32'd0);
    step();
    chk("rw_tie_ackA", {31'd0, ackA}, 32'd1);
    reqA = 0; writeA = 0;
    step();                                   // IDLE
    step();                                   // ACCESS for B
    chk("rw_then_grantB", {31'd0, grantB}, 32'd1);
    chk("rw_then_addrB", {14'd0, busAddr}, 32'h2);
    step();
    chk("rw_then_ackB", {31'd0, ackB}, 32'd1);
    reqB = 0; writeB = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
